// File: rtl/byte_mem_pkg.sv
// Shared types and default sizing for the byte-wide memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package byte_mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_mem_if.sv
// Request/response bundle between a requester (master) and byte_mem_ctrl (slave).
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake; rsp_valid is a one-cycle pulse with no ready.
// Ports: req_valid, req_ready, req_we, req_addr, req_wdata, req_be, rsp_valid, rsp_rdata.
interface byte_mem_if
  import byte_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  localparam int N = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [N-1:0]      req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/byte_ram.sv
// Single-port DEPTH x 8 storage, synchronous write, registered read (read-before-write).
// Latency: rdata valid one cycle after addr is presented.
// Backpressure: none; one access per cycle. Contents are deliberately not reset.
// Ports: clk, we, addr, wdata, rdata.
module byte_ram
  import byte_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Word access controller serialising each request into N byte operations on byte_ram.
// Latency: rsp_valid N+1 cycles after the accepting edge; one request per N+2 cycles.
// Backpressure: req_ready high only in IDLE; the in-flight request ignores req_* changes.
// Ports: clk, rst_n (async, active-low), bus (byte_mem_if.slave).
module byte_mem_ctrl
  import byte_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit BIG_END = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  byte_mem_if.slave  bus
);

  localparam int N     = DATA_W / 8;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
    $fatal(1, "byte_mem_ctrl: DATA_W must be a multiple of 8 and at least 8");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              rdy;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [N-1:0]      be_q;
  logic [DATA_W-1:0] word_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [CNT_W-1:0]  lane;
  logic              last;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [DATA_W-1:0] word_nxt;

  // Operation k touches the k-th byte walking away from the anchor address:
  // downwards for big-endian, upwards for little-endian. Wraps mod DEPTH.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W:0]    k);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(k);
    return BIG_END ? (base - off) : (base + off);
  endfunction

  // Word lane held by operation k (the anchor byte is the MSB when big-endian).
  function automatic logic [CNT_W-1:0] lane_of(input logic [CNT_W-1:0] k);
    return BIG_END ? (CNT_W'(N - 1) - k) : k;
  endfunction

  always_comb begin
    lane      = lane_of(cnt);
    last      = (cnt == CNT_W'(N - 1));
    ram_we    = (state == XFER) && we_q && be_q[lane];
    ram_wdata = wdata_q[{lane, 3'b000} +: 8];
    word_nxt  = word_q;
    word_nxt[{lane, 3'b000} +: 8] = ram_rdata;
    // Reads are issued one step ahead so byte k's data is on ram_rdata during
    // XFER step k and the last lane can be folded straight into rsp_rdata.
    // In IDLE the anchor byte is prefetched from the live request address.
    if (state == XFER) begin
      ram_addr = we_q ? byte_addr(addr_q, {1'b0, cnt})
                      : byte_addr(addr_q, {1'b0, cnt} + (CNT_W + 1)'(1));
    end else begin
      ram_addr = bus.req_addr;
    end
  end

  byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rdy         <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      word_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && rdy) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt     <= '0;
            rdy     <= 1'b0;
            state   <= XFER;
          end
        end
        XFER: begin
          word_q <= word_nxt;
          if (last) begin
            cnt         <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? '0 : word_nxt;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          rsp_valid_q <= 1'b0;
          rdy         <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = rdy;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl: 16-bit big-endian instance plus 32-bit little-endian instance.
// Latency: checks rsp_valid at N+1 cycles after acceptance.
// Backpressure: checks req_ready low while busy and back-to-back spacing.
module tb_byte_mem_ctrl;
  import byte_mem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  byte_mem_if #(.DATA_W(16), .ADDR_W(14)) bus ();
  byte_mem_if #(.DATA_W(32), .ADDR_W(14)) bus32 ();

  byte_mem_ctrl #(.DATA_W(16), .ADDR_W(14), .BIG_END(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  byte_mem_ctrl #(.DATA_W(32), .ADDR_W(14), .BIG_END(1'b0)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request on the 16-bit port; scrambles req_* after acceptance.
  task automatic xact(input logic we, input logic [13:0] a, input logic [15:0] d,
                      input logic [1:0] be, input logic [15:0] exp, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, ".ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = ~a;
    bus.req_wdata = ~d;
    bus.req_be    = ~be;
    @(negedge clk);
    lat = 1;
    chk({tag, ".ready_busy"}, 32'(bus.req_ready), 32'd0);
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd3);
    chk({tag, ".rdata"}, 32'(bus.rsp_rdata), 32'(exp));
    @(negedge clk);
    chk({tag, ".pulse_end"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic xact32(input logic we, input logic [13:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
    int lat;
    @(negedge clk);
    bus32.req_valid = 1'b1;
    bus32.req_we    = we;
    bus32.req_addr  = a;
    bus32.req_wdata = d;
    bus32.req_be    = 4'hF;
    @(posedge clk);
    #1;
    bus32.req_valid = 1'b0;
    bus32.req_addr  = ~a;
    @(negedge clk);
    lat = 1;
    while (!bus32.rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd5);
    chk({tag, ".rdata"}, bus32.rsp_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_t[2];
    int rsp_t[2];
    logic [15:0] rd[2];
    int na;
    int nr;
    int pulses;

    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_be      = '0;
    bus32.req_valid = 1'b0;
    bus32.req_we    = 1'b0;
    bus32.req_addr  = '0;
    bus32.req_wdata = '0;
    bus32.req_be    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(bus.req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known old contents at 0x20/0x21 for the reset scenario later
    xact(1'b1, 14'h0021, 16'h0000, 2'b11, 16'h0000, "init");

    // Full write then read, big-endian
    xact(1'b1, 14'h0011, 16'hA55A, 2'b11, 16'h0000, "w_a55a");
    chk("w_a55a.mem11", 32'(dut.u_ram.mem[14'h0011]), 32'hA5);
    chk("w_a55a.mem10", 32'(dut.u_ram.mem[14'h0010]), 32'h5A);
    xact(1'b0, 14'h0011, 16'hFFFF, 2'b00, 16'hA55A, "r_a55a");

    // Partial write: only the LSB lane is enabled
    xact(1'b1, 14'h0011, 16'h1234, 2'b01, 16'h0000, "w_1234");
    chk("w_1234.mem11", 32'(dut.u_ram.mem[14'h0011]), 32'hA5);
    xact(1'b0, 14'h0011, 16'h0000, 2'b11, 16'hA534, "r_a534");

    // Wrap below address zero
    xact(1'b1, 14'h0000, 16'hBEEF, 2'b11, 16'h0000, "w_beef");
    chk("w_beef.mem0000", 32'(dut.u_ram.mem[14'h0000]), 32'hBE);
    chk("w_beef.mem3fff", 32'(dut.u_ram.mem[14'h3FFF]), 32'hEF);
    xact(1'b0, 14'h0000, 16'h0000, 2'b11, 16'hBEEF, "r_beef");

    // Back-to-back reads with req_valid held high
    na = 0;
    nr = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 14'h0011;
    bus.req_be    = 2'b11;
    for (int c = 0; c < 16; c++) begin
      if (bus.rsp_valid) begin
        if (nr < 2) begin
          rsp_t[nr] = c;
          rd[nr]    = bus.rsp_rdata;
        end
        nr++;
      end
      if (bus.req_valid && bus.req_ready) begin
        if (na < 2) acc_t[na] = c;
        na++;
        if (na == 2) begin
          @(posedge clk);
          #1;
          bus.req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("b2b.accepts", 32'(na), 32'd2);
    chk("b2b.responses", 32'(nr), 32'd2);
    chk("b2b.accept_gap", 32'(acc_t[1] - acc_t[0]), 32'd4);
    chk("b2b.rsp_gap", 32'(rsp_t[1] - rsp_t[0]), 32'd4);
    chk("b2b.first_latency", 32'(rsp_t[0] - acc_t[0]), 32'd3);
    chk("b2b.rdata0", 32'(rd[0]), 32'hA534);
    chk("b2b.rdata1", 32'(rd[1]), 32'hA534);

    // Reset during the second XFER cycle of a write
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 14'h0021;
    bus.req_wdata = 16'hCAFE;
    bus.req_be    = 2'b11;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    chk("rst_mid.no_rsp", 32'(pulses), 32'd0);
    chk("rst_mid.ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid.mem21", 32'(dut.u_ram.mem[14'h0021]), 32'hCA);
    chk("rst_mid.mem20", 32'(dut.u_ram.mem[14'h0020]), 32'h00);
    xact(1'b0, 14'h0021, 16'h0000, 2'b11, 16'hCA00, "rst_mid.read");

    // 32-bit little-endian instance
    xact32(1'b1, 14'h0100, 32'h11223344, 32'h0, "le32_w");
    chk("le32.mem100", 32'(dut32.u_ram.mem[14'h0100]), 32'h44);
    chk("le32.mem101", 32'(dut32.u_ram.mem[14'h0101]), 32'h33);
    chk("le32.mem102", 32'(dut32.u_ram.mem[14'h0102]), 32'h22);
    chk("le32.mem103", 32'(dut32.u_ram.mem[14'h0103]), 32'h11);
    xact32(1'b0, 14'h0100, 32'h0, 32'h11223344, "le32_r");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/byte_mem_ctrl.md
BYTE_MEM_CTRL -- requirements
Module: byte_mem_ctrl

Interface
REQ-001 Parameter DATA_W, 16, access word width in bits; SHALL be a multiple of 8 and at least 8; N = DATA_W/8 bytes per word.
REQ-002 Parameter ADDR_W, 14, byte address width; DEPTH = 2**ADDR_W bytes.
REQ-003 Parameter BIG_END, 1, byte order: 1 = byte i (0 = LSB) at addr-(N-1-i), so the MSB is at addr; 0 = byte i at addr+i.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  byte address of the word's anchor byte.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_be  input  N  per-byte write enable; bit i gates byte i; ignored on reads.
REQ-012 rsp_valid  output  1  single-cycle completion pulse for every accepted request.
REQ-013 rsp_rdata  output  DATA_W  read word; valid only while rsp_valid is 1 after a read; 0 after a write.

Function
REQ-014 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_we, req_addr, req_wdata and req_be SHALL be latched at that edge.
REQ-015 FSM states SHALL be IDLE, XFER and DONE; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE->XFER on acceptance with byte counter cnt=0; XFER SHALL last exactly N cycles, performing one byte operation per cycle for byte cnt, then go to DONE; DONE SHALL last one cycle, then go to IDLE.
REQ-017 The byte address for byte cnt SHALL be computed modulo DEPTH from the latched address per REQ-003; underflow and overflow SHALL wrap (e.g. addr 0, BIG_END=1, N=2: LSB at DEPTH-1).
REQ-018 Write: byte cnt SHALL be stored only if latched be[cnt]=1; disabled bytes still consume their cycle and stay unchanged.
REQ-019 Read: byte RAM read data SHALL arrive one cycle after its address and SHALL be assembled into lane cnt of an internal word register; lanes are fully assembled before DONE.
REQ-020 rsp_valid SHALL be 1 exactly in the DONE cycle, i.e. N+1 cycles after the accepting edge; latency from acceptance to rsp_valid = N+1 cycles; throughput = one request per N+2 cycles.
REQ-021 req_valid deasserting or req inputs changing while in XFER/DONE SHALL have no effect on the transfer in flight.
REQ-022 A read issued after a write completes SHALL return the written bytes (no stale data).
REQ-023 Outputs rsp_valid and rsp_rdata SHALL be registered.

Reset
REQ-024 On rst_n=0: state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, req_ready=1 after release; the request in flight SHALL be dropped with no response.
REQ-025 Storage contents SHALL NOT be reset; bytes written before a mid-XFER reset SHALL persist, unwritten bytes keep old values.

Structure
REQ-026 A shared package byte_mem_pkg SHALL hold the FSM state enum and the default DATA_W/ADDR_W constants.
REQ-027 Storage SHALL be a sub-module byte_ram: DEPTH x 8, one port, synchronous write, registered one-cycle read.
REQ-028 Elaboration SHALL fail if DATA_W%8 != 0 or DATA_W < 8.

Verification (DATA_W=16, ADDR_W=14, BIG_END=1 unless noted)
REQ-029 Write 0xA55A, addr 0x0011, be=2'b11 -> byte 0x11=0xA5, 0x10=0x5A; rsp_valid at cycle 3 after acceptance; read of 0x0011 returns 0xA55A.
REQ-030 After REQ-029, write 0x1234, be=2'b01, addr 0x0011 -> read returns 0xA534.
REQ-031 Write 0xBEEF, addr 0x0000 -> byte 0x0000=0xBE, byte 0x3FFF=0xEF; read returns 0xBEEF.
REQ-032 req_valid held high continuously with two back-to-back reads -> second accepted only at the next IDLE, 4 cycles after the first; rsp_valid pulses are exactly 4 cycles apart.
REQ-033 rst_n=0 on the second XFER cycle of write 0xCAFE at 0x0021 (old 0x0000) -> no rsp_valid; req_ready=1 after release; read returns 0xCA00.
REQ-034 BIG_END=0, DATA_W=32: write 0x11223344 at 0x0100 -> bytes 0x100..0x103 = 44,33,22,11; rsp_valid at cycle 5 after acceptance.
